// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_BLANK_EN to enable the registered leading-zero BLANK mask.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                CLK,
   input  logic                CLR_N,
   input  logic                START,
   input  logic [WIDTH-1:0]    BIN,
   output logic                BUSY,
   output logic                DONE,
   output logic [4*DIGITS-1:0] BCD,
   output logic                OVF,
   output logic [DIGITS-1:0]   BLANK
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [DW-1:0]   dig, dig_n, adj;
   logic [CW-1:0]   cnt;
   logic            sticky, sticky_n;
   logic [DW-1:0]   bcd_q;
   logic            ovf_q;
   logic            load;
   logic            last;

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (START) begin
               load    = 1'b1;
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last) state_n = S_DONE;
         end
         S_DONE: begin
            if (START) begin
               load    = 1'b1;
               state_n = S_SHIFT;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Add-3 is per digit with no inter-digit carry; the shift moves bits up.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
         else                       adj[4*i +: 4] = dig[4*i +: 4];
      end
      dig_n    = {adj[DW-2:0], shreg[WIDTH-1]};
      shreg_n  = shreg << 1;
      sticky_n = sticky | adj[DW-1];
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         shreg  <= '0;
         dig    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
         bcd_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (load) begin
         shreg  <= BIN;
         dig    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (state == S_SHIFT) begin
         shreg  <= shreg_n;
         dig    <= dig_n;
         sticky <= sticky_n;
         if (last) begin
            bcd_q <= dig_n;
            ovf_q <= sticky_n;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_n, blank_q;
   logic              blank_z;

   // Digit 0 is never blanked so a zero result still shows one "0".
   always_comb begin
      blank_n = '0;
      blank_z = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         blank_z    = blank_z & (dig_n[4*i +: 4] == 4'd0);
         blank_n[i] = blank_z;
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N)                          blank_q <= '0;
      else if (state == S_SHIFT && last)   blank_q <= blank_n;
   end

   assign BLANK = blank_q;
`else
   assign BLANK = '0;
`endif

   assign BUSY = (state == S_SHIFT);
   assign DONE = (state == S_DONE);
   assign BCD  = bcd_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: a 5-digit and a 4-digit instance.
// Covers latency, held results, ignored START, back-to-back, reset abort.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        start5 = 1'b0, start4 = 1'b0;
   logic [15:0] bin5 = '0, bin4 = '0;
   logic        busy5, done5, ovf5, busy4, done4, ovf4;
   logic [19:0] bcd5;
   logic [15:0] bcd4;
   logic [4:0]  blank5;
   logic [3:0]  blank4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
      .CLK(clk), .CLR_N(clr_n), .START(start5), .BIN(bin5),
      .BUSY(busy5), .DONE(done5), .BCD(bcd5), .OVF(ovf5), .BLANK(blank5)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
      .CLK(clk), .CLR_N(clr_n), .START(start4), .BIN(bin4),
      .BUSY(busy4), .DONE(done4), .BCD(bcd4), .OVF(ovf4), .BLANK(blank4)
   );

   typedef struct {
      bit          sel;
      logic [15:0] bin;
      logic [19:0] bcd;
      logic        ovf;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] exp_blank(input logic [19:0] b,
                                            input int nd);
      logic [4:0] r;
      logic       z;
      r = '0;
      z = 1'b1;
`ifdef BIN2BCD_BLANK_EN
      for (int i = nd - 1; i >= 1; i--) begin
         z    = z & (b[4*i +: 4] == 4'd0);
         r[i] = z;
      end
`else
      z = z & (nd > 0);
`endif
      return r;
   endfunction

   task automatic run_conv(input bit sel, input logic [15:0] b,
                           output logic [19:0] r_bcd, output logic r_ovf,
                           output logic [4:0] r_blank, output bit lat_ok);
      logic bz, dn;
      @(negedge clk);
      if (sel) begin start4 = 1'b1; bin4 = b; end
      else     begin start5 = 1'b1; bin5 = b; end
      @(posedge clk); #1;
      start4 = 1'b0;
      start5 = 1'b0;
      lat_ok = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
         bz = sel ? busy4 : busy5;
         dn = sel ? done4 : done5;
         if (bz !== (n < 16) || dn !== (n == 16)) lat_ok = 1'b0;
      end
      r_bcd   = sel ? {4'h0, bcd4} : bcd5;
      r_ovf   = sel ? ovf4 : ovf5;
      r_blank = sel ? {1'b0, blank4} : blank5;
      @(posedge clk); #1;
      bz = sel ? busy4 : busy5;
      dn = sel ? done4 : done5;
      if (bz !== 1'b0 || dn !== 1'b0) lat_ok = 1'b0;
   endtask

   initial begin
      logic [19:0] r_bcd, last5;
      logic        r_ovf;
      logic [4:0]  r_blank;
      bit          lat_ok;
      int          cnt;
      int          seen;

      vecs[0]  = '{0, 16'd0,     20'h00000, 1'b0};
      vecs[1]  = '{0, 16'd1,     20'h00001, 1'b0};
      vecs[2]  = '{0, 16'd9,     20'h00009, 1'b0};
      vecs[3]  = '{0, 16'd10,    20'h00010, 1'b0};
      vecs[4]  = '{0, 16'd99,    20'h00099, 1'b0};
      vecs[5]  = '{0, 16'd100,   20'h00100, 1'b0};
      vecs[6]  = '{0, 16'd255,   20'h00255, 1'b0};
      vecs[7]  = '{0, 16'd9999,  20'h09999, 1'b0};
      vecs[8]  = '{0, 16'd10000, 20'h10000, 1'b0};
      vecs[9]  = '{0, 16'd12345, 20'h12345, 1'b0};
      vecs[10] = '{0, 16'd32768, 20'h32768, 1'b0};
      vecs[11] = '{0, 16'd40960, 20'h40960, 1'b0};
      vecs[12] = '{0, 16'd65535, 20'h65535, 1'b0};
      vecs[13] = '{0, 16'd7,     20'h00007, 1'b0};
      vecs[14] = '{1, 16'd12345, 20'h02345, 1'b1};
      vecs[15] = '{1, 16'd9999,  20'h09999, 1'b0};
      vecs[16] = '{1, 16'd10000, 20'h00000, 1'b1};
      vecs[17] = '{1, 16'd65535, 20'h05535, 1'b1};
      vecs[18] = '{1, 16'd0,     20'h00000, 1'b0};

      // Reset state, held with no START
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_bcd",   32'(bcd5),   32'h0);
      chk("rst_busy",  32'(busy5),  32'h0);
      chk("rst_done",  32'(done5),  32'h0);
      chk("rst_ovf",   32'(ovf5),   32'h0);
      chk("rst_blank", 32'(blank5), 32'h0);
      chk("rst_bcd4",  32'(bcd4),   32'h0);

      last5 = '0;
      foreach (vecs[i]) begin
         run_conv(vecs[i].sel, vecs[i].bin, r_bcd, r_ovf, r_blank, lat_ok);
         chk($sformatf("lat_%0d", i), 32'(lat_ok), 32'h1);
         chk($sformatf("bcd_%0d", i), 32'(r_bcd), 32'(vecs[i].bcd));
         chk($sformatf("ovf_%0d", i), 32'(r_ovf), 32'(vecs[i].ovf));
         chk($sformatf("blank_%0d", i), 32'(r_blank),
             32'(exp_blank(vecs[i].bcd, vecs[i].sel ? 4 : 5)));
         if (!vecs[i].sel) last5 = vecs[i].bcd;
      end

      // START during BUSY is ignored; old result held mid-conversion
      @(negedge clk);
      bin5 = 16'd1234; start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      lat_ok = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
         if (busy5 !== (n < 16) || done5 !== (n == 16)) lat_ok = 1'b0;
         if (n == 5) begin start5 = 1'b1; bin5 = 16'd9; end
         if (n == 6) start5 = 1'b0;
         if (n == 8) chk("hold_bcd", 32'(bcd5), 32'(last5));
      end
      chk("ign_lat",   32'(lat_ok), 32'h1);
      chk("ign_bcd",   32'(bcd5),   32'h01234);
      chk("ign_blank", 32'(blank5), 32'(exp_blank(20'h01234, 5)));
      repeat (2) @(posedge clk);
      #1;
      chk("ign_noq", 32'({busy5, done5}), 32'h0);

      // Back-to-back with START held high
      @(negedge clk);
      bin5 = 16'd100; start5 = 1'b1;
      @(posedge clk); #1;
      cnt = 0;
      while (cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
         if (done5) break;
      end
      chk("b2b_lat1", 32'(cnt),  32'd16);
      chk("b2b_bcd1", 32'(bcd5), 32'h00100);
      bin5 = 16'd7;
      cnt = 0;
      while (cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
         if (done5) break;
      end
      start5 = 1'b0;
      chk("b2b_lat2", 32'(cnt),  32'd17);
      chk("b2b_bcd2", 32'(bcd5), 32'h00007);
      @(posedge clk); #1;
      chk("b2b_idle", 32'({busy5, done5}), 32'h0);

      // Reset in the middle of a conversion
      @(negedge clk);
      bin5 = 16'd12345; start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_busy_pre", 32'(busy5), 32'h1);
      clr_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy5), 32'h0);
      chk("mid_done", 32'(done5), 32'h0);
      chk("mid_bcd",  32'(bcd5),  32'h0);
      chk("mid_ovf",  32'(ovf5),  32'h0);
      @(negedge clk);
      clr_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done5 || busy5) seen++;
      end
      chk("mid_nodone", 32'(seen), 32'h0);
      chk("mid_bcd_hold", 32'(bcd5), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
